// File: rtl/smg_display_arbiter.sv
// smg_display_arbiter: round-robin sharing of one 6-digit seven-segment display
// between NREQ number sources. Each grant is held for a minimum number of cycles
// unless the owner withdraws its request.
module smg_display_arbiter #(
    parameter int unsigned NREQ       = 3,
    parameter int unsigned HOLD_CYC   = 50_000_000,
    parameter int unsigned CNT_W      = 26,
    parameter logic [23:0] IDLE_VALUE = 24'h000000
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*24-1:0]   number_in,
    output logic [23:0]          number_sig,
    output logic [NREQ-1:0]      grant,
    output logic                 switch_pulse,
    output logic                 busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_HOLD
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       number_q, number_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;
    logic              decide;

    // Round-robin scan starting after the last winner; the last winner is checked last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            int unsigned idx;
            idx = (int'(last_q) + k) % int'(NREQ);
            if (!win_found && req[IDX_W'(idx)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(idx);
            end
        end
        // In HOLD the owner is always last_q; decide on expiry or withdrawal.
        decide = (state_q == ST_IDLE) || (cnt_q == '0) || !req[last_q];
    end

    // Next-state, next-grant and next display value.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (decide) begin
            if (win_found) begin
                grant_d = NREQ'(1) << win_idx;
                last_d  = win_idx;
                cnt_d   = CNT_W'(HOLD_CYC - 1);
                state_d = ST_HOLD;
                pulse_d = (grant_q == '0) || (win_idx != last_q);
            end else begin
                grant_d = '0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        // Only the owner's slice is ever selected, so non-owner data cannot leak.
        number_d = IDLE_VALUE;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (grant_d[i]) begin
                number_d = number_in[24*i +: 24];
            end
        end
        busy_d = |grant_d;
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            last_q   <= IDX_W'(NREQ - 1);
            cnt_q    <= '0;
            number_q <= IDLE_VALUE;
            pulse_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            number_q <= number_d;
            pulse_q  <= pulse_d;
            busy_q   <= busy_d;
        end
    end

    assign number_sig   = number_q;
    assign grant        = grant_q;
    assign switch_pulse = pulse_q;
    assign busy         = busy_q;

endmodule
